// File: rtl/sync_up_counter_if.sv
//------------------------------------------------------------------------------
// sync_up_counter_if : control/status bundle for sync_up_counter
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface sync_up_counter_if #(
   parameter int WIDTH = 4
);
   logic             en_i;
   logic             clear_i;
   logic             load_i;
   logic [WIDTH-1:0] load_val_i;
   logic             ack_ovf_i;
   logic [WIDTH-1:0] count_o;
   logic             tc_o;
   logic             wrap_o;
   logic             ovf_o;

   modport master (
      output en_i, clear_i, load_i, load_val_i, ack_ovf_i,
      input  count_o, tc_o, wrap_o, ovf_o
   );

   modport slave (
      input  en_i, clear_i, load_i, load_val_i, ack_ovf_i,
      output count_o, tc_o, wrap_o, ovf_o
   );
endinterface

`default_nettype wire

// File: rtl/sync_up_counter.sv
//------------------------------------------------------------------------------
// sync_up_counter : up counter 0..MAX with clear/load/enable, tc, wrap, ovf.
// Optional macro SYNC_UP_COUNTER_SATURATE_EN: hold at MAX instead of wrapping.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sync_up_counter #(
   parameter int WIDTH = 4,
   parameter int MAX   = 15
) (
   input  wire logic         clk_i,
   input  wire logic         rst_ni,
   sync_up_counter_if.slave  bus
);

   localparam logic [WIDTH-1:0] c_max = WIDTH'(MAX);

   logic [WIDTH-1:0] count_q, count_d;
   logic             wrap_q,  wrap_d;
   logic             ovf_q,   ovf_d;
   logic             w_at_max;

   assign w_at_max = (count_q == c_max);

   always_comb begin
      count_d = count_q;
      wrap_d  = 1'b0;
      ovf_d   = ovf_q;

      // ack is applied first so a same-edge overflow below overrides it
      if (bus.ack_ovf_i) begin
         ovf_d = 1'b0;
      end

      if (bus.clear_i) begin
         count_d = '0;
      end else if (bus.load_i) begin
         count_d = (bus.load_val_i > c_max) ? c_max : bus.load_val_i;
      end else if (bus.en_i) begin
         if (w_at_max) begin
`ifdef SYNC_UP_COUNTER_SATURATE_EN
            count_d = c_max;
`else
            count_d = '0;
            wrap_d  = 1'b1;
`endif
            ovf_d = 1'b1;
         end else begin
            count_d = count_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
         wrap_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         wrap_q  <= wrap_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.count_o = count_q;
   assign bus.tc_o    = w_at_max && bus.en_i;
   assign bus.wrap_o  = wrap_q;
   assign bus.ovf_o   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_sync_up_counter.sv
//------------------------------------------------------------------------------
// tb_sync_up_counter : scoreboard bench, two instances (MAX=15 and MAX=9).
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_sync_up_counter;

   logic       clk      = 1'b0;
   logic       rst_n    = 1'b0;
   logic       en       = 1'b0;
   logic       clear    = 1'b0;
   logic       load     = 1'b0;
   logic       ack      = 1'b0;
   logic [3:0] load_val = 4'd0;

   int n_checks = 0;
   int n_errors = 0;

   sync_up_counter_if #(.WIDTH(4)) bus_a ();
   sync_up_counter_if #(.WIDTH(4)) bus_b ();

   assign bus_a.en_i       = en;
   assign bus_a.clear_i    = clear;
   assign bus_a.load_i     = load;
   assign bus_a.load_val_i = load_val;
   assign bus_a.ack_ovf_i  = ack;
   assign bus_b.en_i       = en;
   assign bus_b.clear_i    = clear;
   assign bus_b.load_i     = load;
   assign bus_b.load_val_i = load_val;
   assign bus_b.ack_ovf_i  = ack;

   sync_up_counter #(.WIDTH(4), .MAX(15)) u_dut_a (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus_a)
   );

   sync_up_counter #(.WIDTH(4), .MAX(9)) u_dut_b (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus_b)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] c;
      logic       w;
      logic       o;
   } exp_t;

   exp_t       sb_a[$];
   exp_t       sb_b[$];
   logic [3:0] mc[2];
   logic       mo[2];
   logic [3:0] mmax[2];
   int         step_no = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s (step %0d): got %0h expected %0h", tag, step_no, obs, exp_v);
      end
   endtask

   // Expected post-edge state from the current inputs, pushed before the edge.
   task automatic model_push();
      for (int i = 0; i < 2; i++) begin
         exp_t e;
         e.c = mc[i];
         e.w = 1'b0;
         e.o = mo[i];
         if (ack) e.o = 1'b0;
         if (clear) begin
            e.c = 4'd0;
         end else if (load) begin
            e.c = (load_val > mmax[i]) ? mmax[i] : load_val;
         end else if (en) begin
            if (mc[i] == mmax[i]) begin
`ifdef SYNC_UP_COUNTER_SATURATE_EN
               e.c = mmax[i];
`else
               e.c = 4'd0;
               e.w = 1'b1;
`endif
               e.o = 1'b1;
            end else begin
               e.c = mc[i] + 4'd1;
            end
         end
         mc[i] = e.c;
         mo[i] = e.o;
         if (i == 0) sb_a.push_back(e);
         else        sb_b.push_back(e);
      end
   endtask

   task automatic step();
      exp_t e;
      model_push();
      @(posedge clk);
      #1;
      step_no++;
      chk("a_queue", 32'(sb_a.size() > 0), 32'd1);
      if (sb_a.size() > 0) begin
         e = sb_a.pop_front();
         chk("a_count", 32'(bus_a.count_o), 32'(e.c));
         chk("a_wrap",  32'(bus_a.wrap_o),  32'(e.w));
         chk("a_ovf",   32'(bus_a.ovf_o),   32'(e.o));
         chk("a_tc",    32'(bus_a.tc_o),    32'((e.c == mmax[0]) && en));
      end
      chk("b_queue", 32'(sb_b.size() > 0), 32'd1);
      if (sb_b.size() > 0) begin
         e = sb_b.pop_front();
         chk("b_count", 32'(bus_b.count_o), 32'(e.c));
         chk("b_wrap",  32'(bus_b.wrap_o),  32'(e.w));
         chk("b_ovf",   32'(bus_b.ovf_o),   32'(e.o));
         chk("b_tc",    32'(bus_b.tc_o),    32'((e.c == mmax[1]) && en));
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_a_count"}, 32'(bus_a.count_o), 32'd0);
      chk({tag, "_a_wrap"},  32'(bus_a.wrap_o),  32'd0);
      chk({tag, "_a_ovf"},   32'(bus_a.ovf_o),   32'd0);
      chk({tag, "_a_tc"},    32'(bus_a.tc_o),    32'd0);
      chk({tag, "_b_count"}, 32'(bus_b.count_o), 32'd0);
      chk({tag, "_b_wrap"},  32'(bus_b.wrap_o),  32'd0);
      chk({tag, "_b_ovf"},   32'(bus_b.ovf_o),   32'd0);
      chk({tag, "_b_tc"},    32'(bus_b.tc_o),    32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      mmax[0] = 4'd15;
      mmax[1] = 4'd9;
      for (int i = 0; i < 2; i++) begin
         mc[i] = 4'd0;
         mo[i] = 1'b0;
      end

      repeat (3) @(posedge clk);
      #1;
      en = 1'b1;
      #1;
      check_zero("reset");

      #2 rst_n = 1'b1;
      repeat (20) step();

      // load clamps to MAX on the MAX=9 instance
      en = 1'b0; load = 1'b1; load_val = 4'd12;
      step();
      en = 1'b1; load_val = 4'd5;
      step();

      // clear beats load
      en = 1'b0; load_val = 4'd7;
      step();
      clear = 1'b1;
      step();
      clear = 1'b0; load = 1'b0;

      ack = 1'b1;
      step();
      ack = 1'b0;

      // b wraps with ack on the same edge; a just counts
      load = 1'b1; load_val = 4'd9;
      step();
      load = 1'b0; en = 1'b1; ack = 1'b1;
      step();
      en = 1'b0; load = 1'b1; load_val = 4'd15; ack = 1'b0;
      step();
      load = 1'b0; en = 1'b1; ack = 1'b1;
      step();
      ack = 1'b0;

      for (int k = 0; k < 80; k++) begin
         en       = ($urandom_range(0, 3) != 0);
         clear    = ($urandom_range(0, 15) == 0);
         load     = ($urandom_range(0, 9) == 0);
         ack      = ($urandom_range(0, 7) == 0);
         load_val = 4'($urandom_range(0, 15));
         step();
      end
      clear = 1'b0; load = 1'b0; ack = 1'b0;

      // asynchronous reset between edges
      en = 1'b0; load = 1'b1; load_val = 4'd6;
      step();
      load = 1'b0;
      #3 rst_n = 1'b0;
      #2;
      check_zero("async_rst");
      for (int i = 0; i < 2; i++) begin
         mc[i] = 4'd0;
         mo[i] = 1'b0;
      end
      #1 rst_n = 1'b1;
      en = 1'b1;
      repeat (12) step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/sync_up_counter.md
# sync_up_counter

Synchronous up counter, the counting-direction counterpart to the team's 4-bit synchronous down counter. Counts from 0 up to a programmable terminal value with enable, synchronous clear and parallel load, and produces terminal-count, registered wrap pulse and sticky overflow outputs for cascading into wider counters or timers. Sits beside the down counter in the counters library and shares its clock domain.

## Interface
- WIDTH, 4, counter width in bits (2..16)
- MAX, 15, terminal value; must satisfy 1 <= MAX <= 2^WIDTH-1
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- en  input  1  count enable
- clear  input  1  synchronous clear to 0
- load  input  1  synchronous parallel load
- load_val  input  WIDTH  value loaded when load=1
- ack_ovf  input  1  clears the sticky overflow flag
- count  output  WIDTH  current count (registered)
- tc  output  1  terminal count, combinational: count==MAX && en
- wrap  output  1  registered one-cycle pulse, high the cycle after count wrapped MAX->0
- ovf  output  1  sticky overflow flag (registered)

## Operation
- Reset (reset=0, async, no clock needed): count=0, wrap=0, ovf=0. tc is then 0 (count=0 != MAX, MAX>=1).
- Per-edge priority: clear > load > en > hold.
- clear=1: count<=0; wrap<=0; ovf unchanged.
- load=1 (clear=0): count<=load_val if load_val<=MAX, else count<=MAX. wrap<=0. Load ignores en.
- en=1 (clear=0, load=0): count<MAX -> count+1, wrap<=0. count==MAX -> count<=0, wrap<=1, ovf<=1.
- en=0, no clear/load: count holds; wrap<=0.
- ack_ovf=1 clears ovf on the edge unless a wrap sets it on the same edge (set wins).
- Arithmetic is WIDTH bits unsigned; no intermediate overflow since increment only occurs when count<MAX.
- Cascade: tc of a low stage drives en of the next stage; upper stage advances on the same edge the low stage wraps.

## Timing
- count updates on the rising clk edge following the inputs; latency 1 cycle for clear/load/increment.
- tc is combinational from count and en; valid within the same cycle, no register delay.
- wrap is high exactly one cycle, in the cycle after the MAX->0 edge; consecutive wraps (MAX=1, en held) give wrap high on alternate cycles only when count re-reaches MAX.
- reset asserted mid-count forces all registers to 0 immediately; release is synchronous-safe (first count edge is the first rising clk after reset=1).
- load and en both high: load wins, no increment that cycle, no wrap.

## Configuration
- SYNC_UP_COUNTER_SATURATE_EN defined: counter saturates at MAX; with en=1 at count==MAX, count holds MAX, wrap stays 0, ovf<=1 (overflow still flagged). tc unchanged.
- Not defined: wrap-around behaviour as in Operation (default).

## Test plan
- Reset then en=1 for 20 cycles, WIDTH=4, MAX=15 -> count 0,1,...,15,0,1,2,3; wrap high one cycle after 15->0; ovf=1 from that edge onward.
- MAX=9, en=1 -> count 0..9,0; tc high only while count=9; wrap pulse once per 10 cycles.
- load=1, load_val=12 with MAX=9 -> count=9 next cycle; load_val=5 with en=1 -> count=5, no increment.
- count=7, assert clear and load together -> count=0; then ack_ovf=1 with ovf=1 -> ovf=0 next edge; ack_ovf on wrapping edge -> ovf stays 1.
- Mid-count (count=6) drive reset=0 between clock edges -> count, wrap, ovf go 0 immediately; release reset, en=1 -> 1 after first edge.
- With SYNC_UP_COUNTER_SATURATE_EN, MAX=15, en=1 for 20 cycles -> count sticks at 15, wrap never asserts, ovf=1 after first edge at 15 with en=1.
